pack_src_arbiter: RTL and testbench

Two-input AXI-Stream packet arbiter that shares the single bit-packing datapath (16-bit tdata, 5-bit bit-count tkeep, tlast framing) between two upstream sources. It grants one source at a time for a whole packet, using round-robin at packet boundaries, and forwards beats through one registered output stage into the packer's input port. It also keeps per-source packet counters and flags illegal tkeep values.

---
 rtl/pack_src_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_pack_src_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pack_src_arbiter.sv
// pack_src_arbiter: two-source AXI-Stream packet arbiter feeding the bit-packer through one output register.
// Optional ARB_WATCHDOG_EN: truncates any packet at MAX_BEATS beats and flags wd_err.
module pack_src_arbiter #(
    parameter int MAX_BEATS = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] s0_tdata,
    input  logic [4:0]  s0_tkeep,
    input  logic        s0_tvalid,
    input  logic        s0_tlast,
    output logic        s0_tready,
    input  logic [15:0] s1_tdata,
    input  logic [4:0]  s1_tkeep,
    input  logic        s1_tvalid,
    input  logic        s1_tlast,
    output logic        s1_tready,
    output logic [15:0] m_tdata,
    output logic [4:0]  m_tkeep,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready,
    output logic [1:0]  grant,
    input  logic        cnt_clr,
    output logic [15:0] pkt_cnt0,
    output logic [15:0] pkt_cnt1,
    output logic        tkeep_err,
    output logic        wd_err
);

    localparam int DATA_W = 16;
    localparam int KEEP_W = 5;
    localparam logic [KEEP_W-1:0] KEEP_MAX = 5'd16;

    if ((MAX_BEATS < 2) || (MAX_BEATS > 255)) begin : g_bad_max_beats
        $error("pack_src_arbiter: MAX_BEATS must be within 2..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic [15:0]         pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0]         pkt_cnt1_q, pkt_cnt1_d;
    logic                tkeep_err_q, tkeep_err_d;

    logic                out_free;
    logic                acc0, acc1, acc;
    logic [DATA_W-1:0]   sel_data;
    logic [KEEP_W-1:0]   sel_keep;
    logic                sel_last;
    logic                keep_bad;
    logic                wd_cut;
    logic                eop;

    // Keep counts above the data width are clamped; zero passes through untouched.
    function automatic logic [KEEP_W-1:0] sat_keep(input logic [KEEP_W-1:0] keep);
        return (keep > KEEP_MAX) ? KEEP_MAX : keep;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s0_tvalid && s1_tvalid) begin
                    state_d = last_grant_q ? BUSY0 : BUSY1;
                end else if (s0_tvalid) begin
                    state_d = BUSY0;
                end else if (s1_tvalid) begin
                    state_d = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (eop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is combinational so a stalled output register blocks the owner in the same cycle.
    always_comb begin
        out_free  = !m_tvalid_q || m_tready;
        s0_tready = (state_q == BUSY0) && out_free;
        s1_tready = (state_q == BUSY1) && out_free;
        grant     = {state_q == BUSY1, state_q == BUSY0};
    end

    always_comb begin
        acc0     = s0_tvalid && s0_tready;
        acc1     = s1_tvalid && s1_tready;
        acc      = acc0 || acc1;
        sel_data = acc1 ? s1_tdata : s0_tdata;
        sel_keep = acc1 ? s1_tkeep : s0_tkeep;
        sel_last = acc1 ? s1_tlast : s0_tlast;
        keep_bad = acc && (sel_keep > KEEP_MAX);
        eop      = acc && (sel_last || wd_cut);
    end

`ifdef ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(MAX_BEATS - 1);

    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       wd_err_q, wd_err_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE) begin
            beat_cnt_d = '0;
        end else if (acc) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
        wd_cut   = acc && !sel_last && (beat_cnt_q == WD_LAST);
        wd_err_d = wd_err_q || wd_cut;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt_q <= '0;
            wd_err_q   <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            wd_err_q   <= wd_err_d;
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_cut = 1'b0;
    assign wd_err = 1'b0;
`endif

    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tkeep_d  = m_tkeep_q;
        m_tlast_d  = m_tlast_q;
        m_tvalid_d = m_tvalid_q;
        if (acc) begin
            m_tdata_d  = sel_data;
            m_tkeep_d  = sat_keep(sel_keep);
            m_tlast_d  = sel_last || wd_cut;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end

        last_grant_d = eop ? acc1 : last_grant_q;
        tkeep_err_d  = tkeep_err_q || keep_bad;

        // A clear in the same cycle as a packet completion wins.
        pkt_cnt0_d = cnt_clr ? 16'd0 : pkt_cnt0_q + {15'd0, eop && acc0};
        pkt_cnt1_d = cnt_clr ? 16'd0 : pkt_cnt1_q + {15'd0, eop && acc1};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
            m_tdata_q    <= '0;
            m_tkeep_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            pkt_cnt0_q   <= '0;
            pkt_cnt1_q   <= '0;
            tkeep_err_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tlast_q    <= m_tlast_d;
            pkt_cnt0_q   <= pkt_cnt0_d;
            pkt_cnt1_q   <= pkt_cnt1_d;
            tkeep_err_q  <= tkeep_err_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tkeep   = m_tkeep_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign tkeep_err = tkeep_err_q;

endmodule

// File: tb/tb_pack_src_arbiter.sv
// Bench for pack_src_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_pack_src_arbiter;

`ifdef ARB_WATCHDOG_EN
    localparam int MB = 4;
    localparam bit WD = 1'b1;
`else
    localparam int MB = 64;
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] s0_tdata = '0, s1_tdata = '0;
    logic [4:0]  s0_tkeep = '0, s1_tkeep = '0;
    logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic        s0_tready, s1_tready;
    logic [15:0] m_tdata;
    logic [4:0]  m_tkeep;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b0;
    logic [1:0]  grant;
    logic        cnt_clr = 1'b0;
    logic [15:0] pkt_cnt0, pkt_cnt1;
    logic        tkeep_err, wd_err;

    pack_src_arbiter #(.MAX_BEATS(MB)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid),
        .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid),
        .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .cnt_clr(cnt_clr),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
        .tkeep_err(tkeep_err), .wd_err(wd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [4:0]  k;
        logic        l;
    } beat_t;

    beat_t q0[$], q1[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    valid_pct = 100;
    int    rdy_pct = 100;

    // Reference model: owner (0 idle, 1 src0, 2 src1), round-robin memory, output slot, counters, flags.
    int          own;
    bit          lg;
    bit          ov;
    beat_t       ob;
    logic [15:0] c0, c1;
    bit          ke, we;
    int          beats;
    bit          acc0, acc1;

    function automatic bit pred_rdy(input int x);
        return (own == x + 1) && (!ov || m_tready);
    endfunction

    task automatic model_reset();
        own = 0; lg = 1'b1; ov = 1'b0; ob = '0; c0 = '0; c1 = '0;
        ke = 1'b0; we = 1'b0; beats = 0; acc0 = 1'b0; acc1 = 1'b0;
    endtask

    task automatic model_update();
        bit    a0, a1, cut, eop;
        beat_t b;
        a0 = s0_tvalid && pred_rdy(0);
        a1 = s1_tvalid && pred_rdy(1);
        b = '0;
        if (a0) b = {s0_tdata, s0_tkeep, s0_tlast};
        if (a1) b = {s1_tdata, s1_tkeep, s1_tlast};
        cut = WD && (a0 || a1) && !b.l && (beats == MB - 1);
        eop = (a0 || a1) && (b.l || cut);
        if (a0 || a1) begin
            ob = {b.d, (b.k > 5'd16) ? 5'd16 : b.k, b.l || cut};
            ov = 1'b1;
            if (b.k > 5'd16) ke = 1'b1;
            if (cut) we = 1'b1;
            beats++;
        end else if (m_tready) begin
            ov = 1'b0;
        end
        if (cnt_clr) begin
            c0 = '0; c1 = '0;
        end else begin
            if (eop && a0) c0 = c0 + 16'd1;
            if (eop && a1) c1 = c1 + 16'd1;
        end
        if (own == 0) begin
            beats = 0;
            if (s0_tvalid && s1_tvalid) own = lg ? 1 : 2;
            else if (s0_tvalid) own = 1;
            else if (s1_tvalid) own = 2;
        end else if (eop) begin
            lg = a1;
            own = 0;
        end
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        acc0 = a0;
        acc1 = a1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("handshake", {s0_tready, s1_tready, grant},
            {pred_rdy(0), pred_rdy(1), own == 2, own == 1});
        chk("output", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {ov, ob.d, ob.k, ob.l});
        chk("status", {pkt_cnt0, pkt_cnt1, tkeep_err, wd_err}, {c0, c1, ke, we});
    endtask

    // Sources hold valid and payload until the model sees the handshake.
    task automatic drive_src();
        if (!(s0_tvalid && !acc0)) begin
            if (q0.size() != 0 && $urandom_range(99) < valid_pct) begin
                s0_tvalid = 1'b1;
                {s0_tdata, s0_tkeep, s0_tlast} = q0[0];
            end else begin
                s0_tvalid = 1'b0;
            end
        end
        if (!(s1_tvalid && !acc1)) begin
            if (q1.size() != 0 && $urandom_range(99) < valid_pct) begin
                s1_tvalid = 1'b1;
                {s1_tdata, s1_tkeep, s1_tlast} = q1[0];
            end else begin
                s1_tvalid = 1'b0;
            end
        end
        m_tready = ($urandom_range(99) < rdy_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_update();
        #1;
        drive_src();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || own != 0 || ov) && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        assert (n < budget) else begin
            miscompares++;
            $error("FAIL drain: %0d cycles used, limit %0d", n, budget);
        end
    endtask

    task automatic push_rand(input int src);
        int    len;
        beat_t b;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++) begin
            b.d = 16'($urandom);
            b.k = ($urandom_range(9) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
            b.l = (i == len - 1);
            if (src == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0]  trace;
        logic [15:0]  got_d[$];
        logic         got_l[$];
        bit           pat[10];

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_values", {m_tdata, m_tkeep, m_tvalid, m_tlast, s0_tready, s1_tready, grant,
                             pkt_cnt0, pkt_cnt1, tkeep_err, wd_err}, 64'd0);
        reset_n = 1'b1;
        drive_src();
        tick();
        tick();

        // Tie twice: port 0 first each time, one idle cycle between packets.
        for (int r = 0; r < 2; r++) begin
            q0.push_back({16'hB000, 5'd16, 1'b0}); q0.push_back({16'hB001, 5'd16, 1'b1});
            q1.push_back({16'hC000, 5'd16, 1'b0}); q1.push_back({16'hC001, 5'd16, 1'b1});
            drive_src();
            for (int i = 0; i < 6; i++) begin
                tick();
                #1;
                trace[11 - 2*i -: 2] = grant;
            end
            chk("tie_grant_trace", trace, 12'b01_01_00_10_10_00);
        end

        // Single source, 3 beats.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        q0.push_back({16'hA001, 5'd16, 1'b0});
        q0.push_back({16'hA002, 5'd16, 1'b0});
        q0.push_back({16'hA003, 5'd8,  1'b1});
        drive_src();
        tick(); #1;
        chk("single_grant", {grant, s0_tready}, {2'b01, 1'b1});
        tick(); #1;
        chk("single_beat1", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, 16'hA001, 5'd16, 1'b0});
        tick(); #1;
        chk("single_beat2", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, 16'hA002, 5'd16, 1'b0});
        tick(); #1;
        chk("single_beat3", {m_tvalid, m_tdata, m_tkeep, m_tlast, grant}, {1'b1, 16'hA003, 5'd8, 1'b1, 2'b00});
        chk("single_cnt", pkt_cnt0, 16'd1);
        tick(); #1;
        chk("single_after", {m_tvalid, grant}, 3'b000);

        // Backpressure on a 4-beat source 1 packet.
        pat = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
        for (int i = 0; i < 4; i++) q1.push_back({16'hD000 + 16'(i), 5'd16, i == 3});
        drive_src();
        for (int i = 0; i < 10; i++) begin
            tick();
            m_tready = pat[i];
            #1;
            if (m_tvalid && !m_tready) chk("bp_ready_low", s1_tready, 1'b0);
            if (m_tvalid && m_tready) got_d.push_back(m_tdata);
        end
        chk("bp_count", got_d.size(), 4);
        for (int i = 0; i < got_d.size() && i < 4; i++) chk("bp_data", got_d[i], 16'hD000 + 16'(i));
        m_tready = 1'b1;
        drain(50);

        // Illegal keep clamps and sticks.
        q0.push_back({16'hE000, 5'd20, 1'b0});
        q0.push_back({16'hE001, 5'd16, 1'b0});
        q0.push_back({16'hE002, 5'd0,  1'b1});
        drive_src();
        tick();
        tick(); #1;
        chk("keep_clamp", {m_tdata, m_tkeep, tkeep_err}, {16'hE000, 5'd16, 1'b1});
        tick(); #1;
        chk("keep_sticky1", {m_tkeep, tkeep_err}, {5'd16, 1'b1});
        tick(); #1;
        chk("keep_zero", {m_tkeep, m_tlast, tkeep_err}, {5'd0, 1'b1, 1'b1});
        drain(50);

        // Long packet: truncated at MB beats only when the watchdog is built in.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 7; i++) q1.push_back({16'hF000 + 16'(i), 5'd16, i == 6});
        got_d.delete();
        drive_src();
        for (int i = 0; i < 40; i++) begin
            tick(); #1;
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_l.push_back(m_tlast);
            end
        end
        chk("wd_count", got_l.size(), 7);
        for (int i = 0; i < got_l.size() && i < 7; i++) begin
            chk("wd_data", got_d[i], 16'hF000 + 16'(i));
            chk("wd_last", got_l[i], (i == 6) || (WD && i == MB - 1));
        end
        chk("wd_err", wd_err, WD);
        chk("wd_cnt", pkt_cnt1, WD ? 16'd2 : 16'd1);

        // Clear and increment in the same cycle.
        q1.push_back({16'h1234, 5'd4, 1'b1});
        drive_src();
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        #1;
        chk("clr_wins", pkt_cnt1, 16'd0);
        drain(20);

        // Counter wrap.
        force dut.pkt_cnt0_q = 16'hFFFF;
        c0 = 16'hFFFF;
        #1;
        release dut.pkt_cnt0_q;
        q0.push_back({16'h5678, 5'd16, 1'b1});
        drive_src();
        drain(20);
        chk("cnt_wrap", pkt_cnt0, 16'd0);

        // Reset in the middle of a packet.
        for (int i = 0; i < 5; i++) q0.push_back({16'h7000 + 16'(i), 5'd16, i == 4});
        drive_src();
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        chk("reset_mid", {m_tdata, m_tkeep, m_tvalid, m_tlast, s0_tready, s1_tready, grant,
                          pkt_cnt0, pkt_cnt1, tkeep_err, wd_err}, 64'd0);
        model_reset();
        #1;
        reset_n = 1'b1;
        drain(50);

        // Random traffic.
        valid_pct = 70;
        rdy_pct = 70;
        for (int i = 0; i < 800; i++) begin
            if (q0.size() < 3) push_rand(0);
            if (q1.size() < 3) push_rand(1);
            cnt_clr = ($urandom_range(49) == 0);
            tick();
        end
        cnt_clr = 1'b0;
        valid_pct = 100;
        rdy_pct = 100;
        drain(200);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
